pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
Controller for the 433.92 MHz carrier PLL in the RDS transmitter. It holds the PLL in reset, releases it, and waits for lock. The lock must stay stable for a settle period before the block enables the RF output. If lock does not arrive, the block retries a bounded number of times and then latches a fault. If lock is lost during operation, RF is gated off and the PLL is restarted.

Parameters:
RESET_CYCLES, 16, cycles pll_rst is held high per attempt (>=1)
SETTLE_CYCLES, 1024, consecutive synchronized lock-high cycles required before RF enable (>=1)
LOCK_TIMEOUT, 65536, max cycles in WAIT_LOCK before an attempt counts as failed (>=2)
MAX_RETRIES, 7, failed attempts allowed before FAULT (1..15)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous reset, active low
enable  in  1  level; 1 = bring up and keep carrier, 0 = shut down
pll_lock  in  1  PLL lock indicator, asynchronous to clk
clear_fault  in  1  single-cycle pulse; leaves FAULT
pll_rst  out  1  PLL reset, active high
rf_enable  out  1  carrier output gate
state  out  3  IDLE=0 RESET=1 WAIT_LOCK=2 SETTLE=3 RUN=4 FAULT=5
retry_count  out  4  failed attempts since last RUN entry or clear
loss_count  out  8  lock losses while in RUN, saturating at 255
fault  out  1  high while in FAULT

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. Every output is registered.
- Reset values: state=IDLE, pll_rst=1, rf_enable=0, fault=0, retry_count=0, loss_count=0. Both lock synchronizer flops clear to 0.
- Lock synchronizer: lock_s is pll_lock through a 2-flop synchronizer. The FSM uses only lock_s, so a change on pll_lock reaches lock_s after 2 cycles.
- One shared cycle counter. Its width is clog2 of the largest of RESET_CYCLES, SETTLE_CYCLES and LOCK_TIMEOUT. It clears on every state change.
- IDLE: pll_rst=1, rf_enable=0. If enable=1, go to RESET next cycle.
- RESET: pll_rst=1 for exactly RESET_CYCLES cycles, then go to WAIT_LOCK. pll_rst goes low on the first WAIT_LOCK cycle.
- WAIT_LOCK: pll_rst=0.
  - If lock_s=1, go to SETTLE next cycle.
  - If instead the counter reaches LOCK_TIMEOUT-1, retry_count increments. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to RESET.
- SETTLE: rf_enable=0.
  - If lock_s=0 on any cycle, return to WAIT_LOCK. The timeout counter restarts and retry_count does not change.
  - After SETTLE_CYCLES consecutive cycles with lock_s=1, go to RUN.
- RUN: rf_enable=1 starting the first RUN cycle. retry_count clears to 0 on RUN entry.
  - If lock_s=0, go to RESET next cycle: rf_enable=0 and pll_rst=1 on that cycle, and loss_count increments (saturating).
- FAULT: pll_rst=1, rf_enable=0, fault=1. The block stays here regardless of enable. A clear_fault pulse sends it to IDLE next cycle with fault=0 and retry_count=0.
- enable=0 in any state except FAULT sends the block to IDLE next cycle. This takes priority over every other transition in the same cycle, including lock loss: loss_count is not incremented.
- clear_fault outside FAULT is ignored.
- rst_n low in any state returns all registers to reset values on the next edge, including mid-RESET or mid-RUN.
- loss_count clears only on rst_n.

Test Plan:
Use bench params RESET_CYCLES=4, SETTLE_CYCLES=8, LOCK_TIMEOUT=16, MAX_RETRIES=2. Cycle numbers are relative to the edge where enable=1 is first sampled (cycle 0).
1. Nominal bring-up: raise pll_lock at cycle 7 and hold it. Required: pll_rst=1 through cycle 4; WAIT_LOCK with pll_rst=0 from cycle 5; lock_s high at cycle 9; SETTLE cycles 10-17; RUN with rf_enable=1 from cycle 18; retry_count=0.
2. Settle glitch: as scenario 1, but pll_lock low for 3 cycles starting at cycle 12. Required: return to WAIT_LOCK; SETTLE restarts after lock_s returns; rf_enable stays 0 until 8 further clean cycles; retry_count stays 0.
3. Never-lock: hold pll_lock=0. Required: WAIT_LOCK lasts 16 cycles; retry_count becomes 1, then 2; FAULT with fault=1, pll_rst=1; toggling enable has no effect; a clear_fault pulse gives IDLE next cycle with retry_count=0.
4. Loss in RUN: from RUN, drop pll_lock. Required: rf_enable=0 and pll_rst=1 exactly 3 cycles after the drop (2 synchronizer cycles plus 1); loss_count=1; relock sequence repeats as scenario 1.
5. Priority: drop enable and pll_lock so both take effect in the same RUN cycle. Required: next state IDLE; loss_count unchanged.
6. Reset mid-operation: assert rst_n=0 for 1 cycle during SETTLE. Required: all outputs at reset values on the next cycle, including loss_count=0.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer for the 433.92 MHz RDS carrier.
// Holds the PLL in reset, releases it, waits for a synchronized lock,
// requires the lock to stay up for a settle window, then gates RF on.
// Failed lock attempts are retried a bounded number of times before a
// latched fault; lock loss while running gates RF off and restarts.
module pll_lock_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       pll_lock,
  input  logic       clear_fault,
  output logic       pll_rst,
  output logic       rf_enable,
  output logic [2:0] state,
  output logic [3:0] retry_count,
  output logic [7:0] loss_count,
  output logic       fault
);

  // One counter serves every timed state, so size it for the longest wait.
  localparam int MAX_AB = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int MAXC   = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CNT_W  = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_WAIT   = 3'd2,
    S_SETTLE = 3'd3,
    S_RUN    = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pll_rst;
  logic             r_rf_enable;
  logic             r_fault;
  logic [3:0]       r_retry;
  logic [7:0]       r_loss;
  logic             r_lock_m;
  logic             r_lock_s;
  logic [3:0]       w_retry_inc;

  assign w_retry_inc = r_retry + 4'd1;

  assign state       = r_state;
  assign pll_rst     = r_pll_rst;
  assign rf_enable   = r_rf_enable;
  assign fault       = r_fault;
  assign retry_count = r_retry;
  assign loss_count  = r_loss;

  // Two-flop synchronizer bringing the asynchronous lock flag into clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock_m <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_lock_m <= pll_lock;
      r_lock_s <= r_lock_m;
    end
  end

  // Sequencer FSM; outputs are registered alongside the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_rf_enable <= 1'b0;
      r_fault     <= 1'b0;
      r_retry     <= 4'd0;
      r_loss      <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (!enable && (r_state != S_FAULT)) begin
        // Shutdown wins over everything, including a same-cycle lock loss.
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        r_pll_rst   <= 1'b1;
        r_rf_enable <= 1'b0;
        r_fault     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (enable) begin
              r_state   <= S_RESET;
              r_cnt     <= '0;
              r_pll_rst <= 1'b1;
            end
          end
          S_RESET: begin
            if (r_cnt == RESET_LAST) begin
              r_state   <= S_WAIT;
              r_cnt     <= '0;
              r_pll_rst <= 1'b0;
            end
          end
          S_WAIT: begin
            if (r_lock_s) begin
              r_state <= S_SETTLE;
              r_cnt   <= '0;
            end else if (r_cnt == TIMEOUT_LAST) begin
              r_retry   <= w_retry_inc;
              r_cnt     <= '0;
              r_pll_rst <= 1'b1;
              if (w_retry_inc == RETRY_LIMIT) begin
                r_state <= S_FAULT;
                r_fault <= 1'b1;
              end else begin
                r_state <= S_RESET;
              end
            end
          end
          S_SETTLE: begin
            // Any dropout restarts the lock wait without charging a retry.
            if (!r_lock_s) begin
              r_state <= S_WAIT;
              r_cnt   <= '0;
            end else if (r_cnt == SETTLE_LAST) begin
              r_state     <= S_RUN;
              r_cnt       <= '0;
              r_rf_enable <= 1'b1;
              r_retry     <= 4'd0;
            end
          end
          S_RUN: begin
            if (!r_lock_s) begin
              r_state     <= S_RESET;
              r_cnt       <= '0;
              r_pll_rst   <= 1'b1;
              r_rf_enable <= 1'b0;
              if (r_loss != 8'hFF) begin
                r_loss <= r_loss + 8'd1;
              end
            end
          end
          S_FAULT: begin
            if (clear_fault) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_fault <= 1'b0;
              r_retry <= 4'd0;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_rf_enable <= 1'b0;
            r_fault     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
// Row k of the table is one clock cycle: inputs driven during the cycle
// (sampled at its closing edge) and the outputs expected during it.
module tb_pll_lock_sequencer;

  localparam int RC = 4;
  localparam int SC = 8;
  localparam int LT = 16;
  localparam int MR = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RESET  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       pll_lock;
  logic       clear_fault;
  logic       pll_rst;
  logic       rf_enable;
  logic [2:0] state;
  logic [3:0] retry_count;
  logic [7:0] loss_count;
  logic       fault;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       lock;
    logic       clr;
    logic [2:0] st;
    logic       prst;
    logic       rf;
    logic       flt;
    logic [3:0] retry;
    logic [7:0] loss;
  } vec_t;

  vec_t tab[$];

  pll_lock_sequencer #(
    .RESET_CYCLES (RC),
    .SETTLE_CYCLES(SC),
    .LOCK_TIMEOUT (LT),
    .MAX_RETRIES  (MR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pll_lock   (pll_lock),
    .clear_fault(clear_fault),
    .pll_rst    (pll_rst),
    .rf_enable  (rf_enable),
    .state      (state),
    .retry_count(retry_count),
    .loss_count (loss_count),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(logic r, logic e, logic l, logic c, logic [2:0] s,
                              logic p, logic rf, logic fl, logic [3:0] rt, logic [7:0] ls);
    vec_t v;
    v.rst_n = r; v.en = e; v.lock = l; v.clr = c;
    v.st = s; v.prst = p; v.rf = rf; v.flt = fl; v.retry = rt; v.loss = ls;
    tab.push_back(v);
  endfunction

  // Clean bring-up, cycle k relative to the edge sampling enable=1;
  // pll_lock rises in cycle 7.
  function automatic void add_nominal(int k0, int k1, logic [7:0] ls);
    for (int k = k0; k <= k1; k++) begin
      logic [2:0] s;
      logic p;
      logic rf;
      if (k == 0)       begin s = ST_IDLE;   p = 1'b1; rf = 1'b0; end
      else if (k <= 4)  begin s = ST_RESET;  p = 1'b1; rf = 1'b0; end
      else if (k <= 9)  begin s = ST_WAIT;   p = 1'b0; rf = 1'b0; end
      else if (k <= 17) begin s = ST_SETTLE; p = 1'b0; rf = 1'b0; end
      else              begin s = ST_RUN;    p = 1'b0; rf = 1'b1; end
      add(1'b1, 1'b1, (k >= 7), 1'b0, s, p, rf, 1'b0, 4'd0, ls);
    end
  endfunction

  // Lock drops for cycles 12..14 while settling.
  function automatic void add_glitch(logic [7:0] ls);
    for (int k = 0; k <= 27; k++) begin
      logic [2:0] s;
      logic l;
      logic p;
      l = (k >= 7) && !(k >= 12 && k <= 14);
      p = 1'b0;
      if (k == 0)       begin s = ST_IDLE;   p = 1'b1; end
      else if (k <= 4)  begin s = ST_RESET;  p = 1'b1; end
      else if (k <= 9)  s = ST_WAIT;
      else if (k <= 14) s = ST_SETTLE;
      else if (k <= 17) s = ST_WAIT;
      else if (k <= 25) s = ST_SETTLE;
      else              s = ST_RUN;
      // clear_fault outside FAULT must be ignored
      add(1'b1, 1'b1, l, (k == 3), s, p, (s == ST_RUN), 1'b0, 4'd0, ls);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] outs();
    return {state, pll_rst, rf_enable, fault, retry_count, loss_count};
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, required %h", nm, idx, act, exp);
    end
  endtask

  task automatic wait_state(string nm, logic [2:0] s, int max_cyc);
    int n;
    n = 0;
    while (state !== s && n < max_cyc) begin
      step();
      n++;
    end
    chk(nm, n, 32'(state), 32'(s));
  endtask

  task automatic count_in(logic [2:0] s, int max_cyc, output int n);
    n = 0;
    while (state === s && n < max_cyc) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b0; pll_lock = 1'b0; clear_fault = 1'b0;

    // reset state
    add(1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    // nominal bring-up to RUN
    add_nominal(0, 20, 8'd0);
    // loss in RUN: lock drops in cycle 21, RESET three cycles later
    for (int k = 0; k < 3; k++)
      add(1'b1, 1'b1, 1'b0, 1'b0, ST_RUN, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
    add_nominal(1, 20, 8'd1);
    // enable and lock loss land in the same RUN cycle
    add(1'b1, 1'b1, 1'b0, 1'b0, ST_RUN, 1'b0, 1'b1, 1'b0, 4'd0, 8'd1);
    add(1'b1, 1'b1, 1'b0, 1'b0, ST_RUN, 1'b0, 1'b1, 1'b0, 4'd0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 1'b0, ST_RUN, 1'b0, 1'b1, 1'b0, 4'd0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1);
    // settle glitch, then a plain shutdown from RUN
    add_glitch(8'd1);
    add(1'b1, 1'b0, 1'b1, 1'b0, ST_RUN, 1'b0, 1'b1, 1'b0, 4'd0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1);
    // reset pulse during SETTLE clears everything, loss_count included
    add_nominal(0, 12, 8'd1);
    tab[tab.size()-1].rst_n = 1'b0;
    add(1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);

    step();
    step();
    for (int i = 0; i < tab.size(); i++) begin
      rst_n       = tab[i].rst_n;
      enable      = tab[i].en;
      pll_lock    = tab[i].lock;
      clear_fault = tab[i].clr;
      chk("row", i, 32'(outs()),
          32'({tab[i].st, tab[i].prst, tab[i].rf, tab[i].flt, tab[i].retry, tab[i].loss}));
      step();
    end

    // never-lock: two timeouts then FAULT
    rst_n = 1'b1; enable = 1'b1; pll_lock = 1'b0; clear_fault = 1'b0;
    step();
    chk("nl_reset", 0, 32'(state), 32'(ST_RESET));
    wait_state("nl_wait1", ST_WAIT, 10);
    count_in(ST_WAIT, 100, n);
    chk("nl_wait1_len", 0, 32'(n), 32'(LT));
    chk("nl_retry1", 0, 32'({state, pll_rst, retry_count}), 32'({ST_RESET, 1'b1, 4'd1}));
    wait_state("nl_wait2", ST_WAIT, 10);
    count_in(ST_WAIT, 100, n);
    chk("nl_wait2_len", 0, 32'(n), 32'(LT));
    chk("nl_fault", 0, 32'(outs()),
        32'({ST_FAULT, 1'b1, 1'b0, 1'b1, 4'd2, 8'd0}));
    enable = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("nl_fault_en0", 0, 32'({state, fault}), 32'({ST_FAULT, 1'b1}));
    enable = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("nl_fault_en1", 0, 32'({state, fault}), 32'({ST_FAULT, 1'b1}));
    enable = 1'b0;
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    chk("nl_clear", 0, 32'(outs()),
        32'({ST_IDLE, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0}));
    step();
    chk("nl_idle_after", 0, 32'({state, fault}), 32'({ST_IDLE, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
